vote_tally_reader: RTL and testbench

Readout controller for the voting machine's result mode; it acts as the reader on the machine's mode/button/led interface. On `start` it drives `mode` high, presses each candidate button in turn, samples the 8-bit `led` tally, and presents each (candidate, count) pair on a valid/ready result port. It sits between the voting machine and the downstream results logger or display.

---
 rtl/vote_tally_reader.sv | 144 ++++++++++++++
 tb/tb_vote_tally_reader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_tally_reader.sv
// vote_tally_reader: reads the voting machine's tallies in result mode.
// It holds mode high, presses each candidate button in turn, samples the
// 8-bit led tally at the end of a settle window, and offers each
// (candidate, count) pair on a valid/ready result port.
//
// Result handshake: res_valid is high for the whole PRESENT state, and
// res_id/res_count are held stable until a transfer happens. A transfer
// happens at any rising edge where res_valid and res_ready are both high.
// res_valid never drops without a transfer, except on reset.
//
// The FSM state is kept in the enum signal `state` so checkers can bind to it.
module vote_tally_reader #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] led,
  input  logic       res_ready,
  output logic       mode,
  output logic       button1,
  output logic       button2,
  output logic       button3,
  output logic       button4,
  output logic       res_valid,
  output logic [1:0] res_id,
  output logic [7:0] res_count,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRESS   = 3'd1,
    PRESENT = 3'd2,
    GAP     = 3'd3,
    FINISH  = 3'd4
  } state_t;

  // Last counter value of each timed window; the 8-bit counter never wraps
  // for parameter values up to 255.
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] GAP_LAST    = 8'(GAP_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [1:0] idx;
  logic [1:0] idx_next;
  logic [7:0] cnt;
  logic [7:0] cnt_next;
  logic       capture;

  // State, candidate index, counter and captured result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= 8'd0;
      res_id    <= 2'd0;
      res_count <= 8'd0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      cnt   <= cnt_next;
      if (capture) begin
        res_count <= led;
        res_id    <= idx;
      end
    end
  end

  // Next-state logic plus Moore outputs decoded from the registered state.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt;
    capture    = 1'b0;
    mode       = 1'b0;
    button1    = 1'b0;
    button2    = 1'b0;
    button3    = 1'b0;
    button4    = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;

    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = PRESS;
          idx_next   = 2'd0;
          cnt_next   = 8'd0;
        end
      end
      PRESS: begin
        mode    = 1'b1;
        button1 = (idx == 2'd0);
        button2 = (idx == 2'd1);
        button3 = (idx == 2'd2);
        button4 = (idx == 2'd3);
        if (cnt == SETTLE_LAST) begin
          // led is sampled only on this edge, at the end of the hold window.
          capture    = 1'b1;
          cnt_next   = 8'd0;
          state_next = PRESENT;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      PRESENT: begin
        mode      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) begin
          if (idx == 2'd3) begin
            state_next = FINISH;
          end else begin
            idx_next   = idx + 2'd1;
            cnt_next   = 8'd0;
            state_next = GAP;
          end
        end
      end
      GAP: begin
        mode = 1'b1;
        if (cnt == GAP_LAST) begin
          cnt_next   = 8'd0;
          state_next = PRESS;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vote_tally_reader.sv
// Testbench for vote_tally_reader: a default-parameter instance and a
// SETTLE=1/GAP=1 instance, observed one at a time through a select mux.
// A behavioural voting-machine model drives led from the button being held.
module tb_vote_tally_reader;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset     = 1'b1;
  logic       start_a   = 1'b0;
  logic       start_b   = 1'b0;
  logic       res_ready = 1'b1;
  logic [7:0] led       = 8'd0;
  logic       sel       = 1'b0;

  logic       mode_a, b1_a, b2_a, b3_a, b4_a, valid_a, busy_a, done_a;
  logic [1:0] id_a;
  logic [7:0] count_a;
  logic       mode_b, b1_b, b2_b, b3_b, b4_b, valid_b, busy_b, done_b;
  logic [1:0] id_b;
  logic [7:0] count_b;

  vote_tally_reader u_dut (
    .clock(clock), .reset(reset), .start(start_a), .led(led), .res_ready(res_ready),
    .mode(mode_a), .button1(b1_a), .button2(b2_a), .button3(b3_a), .button4(b4_a),
    .res_valid(valid_a), .res_id(id_a), .res_count(count_a), .busy(busy_a), .done(done_a)
  );

  vote_tally_reader #(.SETTLE_CYCLES(1), .GAP_CYCLES(1)) u_dut_fast (
    .clock(clock), .reset(reset), .start(start_b), .led(led), .res_ready(res_ready),
    .mode(mode_b), .button1(b1_b), .button2(b2_b), .button3(b3_b), .button4(b4_b),
    .res_valid(valid_b), .res_id(id_b), .res_count(count_b), .busy(busy_b), .done(done_b)
  );

  // Observed outputs of whichever instance is selected.
  logic       o_mode, o_valid, o_busy, o_done, o_start;
  logic [3:0] o_btn;
  logic [1:0] o_id;
  logic [7:0] o_count;
  assign o_mode  = sel ? mode_b  : mode_a;
  assign o_btn   = sel ? {b4_b, b3_b, b2_b, b1_b} : {b4_a, b3_a, b2_a, b1_a};
  assign o_valid = sel ? valid_b : valid_a;
  assign o_id    = sel ? id_b    : id_a;
  assign o_count = sel ? count_b : count_a;
  assign o_busy  = sel ? busy_b  : busy_a;
  assign o_done  = sel ? done_b  : done_a;
  assign o_start = sel ? start_b : start_a;

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic [9:0] exp_q[$];      // {candidate id, expected count}
  logic [7:0] tally [4];
  bit         glitch = 1'b0;

  int         cyc = 0, e0_cyc = 0, hs_cnt = 0, stall_cnt = 0, dones = 0;
  int         run_len = 0, since_hs = 0, cur_s = 4, cur_g = 2;
  logic [3:0] prev_btn = 4'd0;
  bit         wait_rise = 1'b0, prev_stall = 1'b0, chk_rst = 1'b0, chk_first = 1'b0;
  logic [9:0] held = 10'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- monitor, reference model and led driver ----------------
  initial begin
    logic [9:0] exp_item;
    int         bidx;
    forever begin
      @(negedge clock);
      cyc++;
      cur_s = sel ? 1 : 4;
      cur_g = sel ? 1 : 2;

      if (chk_rst) begin
        check_eq("reset_outputs",
                 {o_mode, o_btn, o_valid, o_id, o_count, o_busy, o_done}, 32'd0);
        chk_rst = 1'b0;
      end
      if (chk_first) begin
        check_eq("first_cycle", {o_busy, o_mode, o_btn, o_valid}, {1'b1, 1'b1, 4'b0001, 1'b0});
        chk_first = 1'b0;
      end

      check_eq("one_button_max", ((o_btn & (o_btn - 4'd1)) == 4'd0), 1);

      if (prev_stall) check_eq("stall_hold", {o_valid, o_id, o_count}, {1'b1, held});
      prev_stall = 1'b0;

      // Button hold width and candidate order.
      if (prev_btn != 4'd0 && o_btn != prev_btn) check_eq("btn_width", run_len, cur_s);
      if (o_btn != 4'd0) begin
        if (o_btn == prev_btn) begin
          run_len++;
        end else begin
          run_len = 1;
          if (exp_q.size() > 0) check_eq("btn_order", o_btn, 4'b0001 << exp_q[0][9:8]);
          else check_eq("btn_unexpected", o_btn, 0);
        end
      end
      prev_btn = o_btn;

      // Cycles from a handshake to the next button rise.
      if (wait_rise) begin
        since_hs++;
        if (o_btn != 4'd0) begin
          check_eq("gap_len", since_hs, cur_g + 1);
          wait_rise = 1'b0;
        end
      end

      if (o_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_result", 1, 0);
        end else begin
          exp_item = exp_q.pop_front();
          check_eq("result", {o_id, o_count}, exp_item);
        end
        hs_cnt++;
        since_hs  = 0;
        wait_rise = (hs_cnt < 4);
      end else if (o_valid) begin
        stall_cnt++;
        prev_stall = 1'b1;
        held       = {o_id, o_count};
      end

      if (o_done) begin
        dones++;
        check_eq("done_time", cyc - e0_cyc - 1, 4 * cur_s + 4 + 3 * cur_g + stall_cnt);
        check_eq("handshakes", hs_cnt, 4);
        check_eq("done_mode_low", o_mode, 0);
      end

      // A start seen while idle begins a readout at the coming edge.
      if (o_start && !o_busy && !reset) begin
        e0_cyc    = cyc;
        hs_cnt    = 0;
        stall_cnt = 0;
        chk_first = 1'b1;
        wait_rise = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back({i[1:0], tally[i]});
      end

      if (reset) begin
        exp_q.delete();
        chk_rst    = 1'b1;
        chk_first  = 1'b0;
        wait_rise  = 1'b0;
        prev_stall = 1'b0;
        prev_btn   = 4'd0;
        run_len    = 0;
      end

      // Voting machine model: tally of the held button; glitches elsewhere.
      if (o_btn != 4'd0) begin
        bidx = o_btn[0] ? 0 : o_btn[1] ? 1 : o_btn[2] ? 2 : 3;
        led  = (glitch && run_len != cur_s) ? 8'hAA : tally[bidx];
      end else begin
        led = glitch ? 8'hAA : 8'($urandom_range(0, 255));
      end
    end
  end

  // ---------------- driver tasks ----------------
  int ready_mode = 0;
  int stall_left = 0;
  bit spam       = 1'b0;

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    case (ready_mode)
      1: begin
        if (o_valid && o_id == 2'd1 && stall_left > 0) begin
          res_ready = 1'b0;
          stall_left--;
        end else begin
          res_ready = 1'b1;
        end
      end
      2:       res_ready = 1'($urandom_range(0, 1));
      default: res_ready = 1'b1;
    endcase
    set_start(spam && o_busy);
  endtask

  task automatic load_tallies(input logic [7:0] t0, t1, t2, t3);
    tally[0] = t0; tally[1] = t1; tally[2] = t2; tally[3] = t3;
  endtask

  task automatic random_tallies();
    for (int i = 0; i < 4; i++) tally[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic run_readout(input int rmode, input bit spam_on, input bit glitch_on);
    int d0;
    d0         = dones;
    ready_mode = rmode;
    stall_left = 5;
    glitch     = glitch_on;
    spam       = spam_on;
    @(posedge clock);
    #1;
    set_start(1'b1);
    for (int i = 0; i < 400 && dones == d0; i++) tick();
    repeat (3) tick();
    check_eq("done_count", dones - d0, 1);
    check_eq("queue_empty", exp_q.size(), 0);
    spam   = 1'b0;
    glitch = 1'b0;
    set_start(1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    load_tallies(8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    // Fixed tallies, ready tied high.
    load_tallies(8'd3, 8'd7, 8'd0, 8'd255);
    run_readout(0, 1'b0, 1'b0);

    // Five-cycle backpressure on candidate 1.
    run_readout(1, 1'b0, 1'b0);

    // Reset during the gap after candidate 0, then a fresh readout.
    random_tallies();
    ready_mode = 0;
    @(posedge clock);
    #1;
    set_start(1'b1);
    tick();
    for (int i = 0; i < 100 && hs_cnt < 1; i++) tick();
    check_eq("reached_gap", hs_cnt, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (2) tick();
    random_tallies();
    run_readout(0, 1'b0, 1'b0);

    // start held while busy must not restart or add results.
    random_tallies();
    run_readout(0, 1'b1, 1'b0);

    // led glitching on every cycle except the sampling edge.
    random_tallies();
    run_readout(0, 1'b0, 1'b1);

    // Random backpressure.
    for (int k = 0; k < 3; k++) begin
      random_tallies();
      run_readout(2, 1'b0, 1'b0);
    end

    // SETTLE_CYCLES=1, GAP_CYCLES=1 instance.
    sel = 1'b1;
    repeat (2) tick();
    load_tallies(8'd3, 8'd7, 8'd0, 8'd255);
    run_readout(0, 1'b0, 1'b0);
    random_tallies();
    run_readout(2, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

endmodule
